data_memory_responder: RTL and testbench

Memory-side responder for the data cache's miss/write-back port. It accepts one word request at a time from the cache (read fill or write-through/write-back), waits a fixed programmable latency, then commits the write or returns read data with a one-cycle `memory_ready` pulse. It sits outside the core, between the cache's `MissAddr`/`Data2Memory`/`MemWrite2Memory` outputs and its `ReadData`/`memory_ready` inputs. It replaces the ad-hoc testbench memory model with synthesizable RTL.

---
 rtl/mem_resp_pkg.sv | 27 ++
 rtl/data_mem_array.sv | 58 +++++
 rtl/data_memory_responder.sv | 164 ++++++++++++++++
 tb/tb_data_memory_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_resp_pkg
//  Description : Shared types and helpers for the data-memory responder:
//                FSM state encoding, latency counter width and the
//                byte-address to word-index helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_resp_pkg;

    // Latency counter width; bounds LATENCY to 1..255.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Word index of a byte address. The caller truncates the result to
    // the array's index width.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr);
        return {2'b00, byte_addr[31:2]};
    endfunction

endpackage : mem_resp_pkg
`default_nettype wire

// File: rtl/data_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_array
//  Description : Single-port synchronous RAM, DEPTH x 32, registered read.
//                The read register only updates when re is high, so the last
//                read word is held.
//  Ports       : CLK    - clock, rising edge
//                rst_n  - async active-low reset (read register only)
//                we     - write enable, writes wdata to addr
//                re     - read enable, loads rdata from addr
//                addr   - word index
//                wdata  - write data
//                rdata  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_array #(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic                     CLK,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Array contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule : data_mem_array
`default_nettype wire

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder
//  Description : Memory-side responder for the data cache miss/write-back
//                port. Accepts one word request, waits LATENCY cycles, then
//                commits the write or returns read data with a one-cycle
//                memory_ready pulse. Bad addresses complete with mem_err.
//  Ports       : CLK, rst_n       - clock / async active-low reset
//                mem_req          - level request, held until memory_ready
//                MemWrite2Memory  - 1 = write, 0 = read
//                MissAddr         - byte address
//                Data2Memory      - write data
//                ReadData         - read result, held until the next read
//                memory_ready     - one-cycle completion pulse
//                mem_err          - range/alignment error, with memory_ready
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder
    import mem_resp_pkg::*;
#(
    parameter int    DEPTH     = 1024,   // power of two, >= 2
    parameter int    LATENCY   = 4,      // 1..255
    parameter string INIT_FILE = ""
) (
    input  logic        CLK,
    input  logic        rst_n,
    input  logic        mem_req,
    input  logic        MemWrite2Memory,
    input  logic [31:0] MissAddr,
    input  logic [31:0] Data2Memory,
    output logic [31:0] ReadData,
    output logic        memory_ready,
    output logic        mem_err
);

    localparam int              AW     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

    state_e           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [31:0]      addr_q,    addr_d;
    logic             wr_q,      wr_d;
    logic [31:0]      wdata_q,   wdata_d;
    logic             ready_q,   ready_d;
    logic             err_q,     err_d;
    logic             rd_zero_q, rd_zero_d;   // last completed read was an error

    logic [31:0] cur_addr;
    logic        cur_wr;
    logic        cur_err;
    logic        go_resp;
    logic        ram_we;
    logic        ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_rdata;

    // In IDLE the live inputs are used so that LATENCY=1 can read the array
    // on the accepting edge; afterwards only the latched copy matters.
    assign cur_addr = (state_q == ST_IDLE) ? MissAddr        : addr_q;
    assign cur_wr   = (state_q == ST_IDLE) ? MemWrite2Memory : wr_q;
    assign cur_err  = (cur_addr[1:0] != 2'b00) || ((cur_addr >> (AW + 2)) != 32'd0);
    assign ram_addr = AW'(word_index(cur_addr));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;
        rd_zero_d = rd_zero_q;
        go_resp   = 1'b0;
        ram_we    = 1'b0;
        ram_re    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    addr_d  = MissAddr;
                    wr_d    = MemWrite2Memory;
                    wdata_d = Data2Memory;
                    cnt_d   = LAT_M1;
                    if (LATENCY == 1) begin
                        go_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!mem_req) begin
                    // Abort: no write, no pulse.
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        go_resp = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ram_we  = wr_q && !err_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering RESP: register the pulse/error and launch the array read
        // so its registered output is valid during RESP.
        if (go_resp) begin
            state_d = ST_RESP;
            ready_d = 1'b1;
            err_d   = cur_err;
            if (!cur_wr) begin
                rd_zero_d = cur_err;
                ram_re    = !cur_err;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    data_mem_array #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .CLK   (CLK),
        .rst_n (rst_n),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign ReadData     = rd_zero_q ? 32'd0 : ram_rdata;
    assign memory_ready = ready_q;
    assign mem_err      = err_q;

endmodule : data_memory_responder
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_responder
//  Description : Self-checking bench. Three responders (LATENCY 4, 1, 255)
//                share clock and reset. Directed table on the LATENCY=4
//                instance, hand-written reset-in-WAIT and back-to-back
//                sequences, and randomized traffic against a word-array model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_req [3];
    logic        wr_i    [3];
    logic [31:0] addr_i  [3];
    logic [31:0] data_i  [3];
    logic [31:0] rd_o    [3];
    logic        rdy_o   [3];
    logic        err_o   [3];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model   [3][16];
    logic [31:0] last_rd [3];

    always #5 CLK = ~CLK;

    function automatic int lat_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 255;
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 4 : (g == 1) ? 1 : 255;
            data_memory_responder #(
                .DEPTH     (1024),
                .LATENCY   (LAT),
                .INIT_FILE ("")
            ) u_dut (
                .CLK             (CLK),
                .rst_n           (rst_n),
                .mem_req         (mem_req[g]),
                .MemWrite2Memory (wr_i[g]),
                .MissAddr        (addr_i[g]),
                .Data2Memory     (data_i[g]),
                .ReadData        (rd_o[g]),
                .memory_ready    (rdy_o[g]),
                .mem_err         (err_o[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request; watches up to LATENCY+4 edges. abort_k>0 drops mem_req
    // after that many edges.
    task automatic run_txn(input int d, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input int abort_k,
                           output bit got, output int lat,
                           output logic [31:0] rd, output bit err);
        int budget;
        budget = lat_of(d) + 4;
        got = 1'b0; lat = 0; rd = '0; err = 1'b0;
        @(negedge CLK);
        wr_i[d] = wr; addr_i[d] = addr; data_i[d] = data; mem_req[d] = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge CLK); #1;
            if (got && k == lat + 1) chk("pulse_width", {31'd0, rdy_o[d]}, 32'd0);
            if (rdy_o[d] && !got) begin
                got = 1'b1; lat = k; rd = rd_o[d]; err = err_o[d];
                mem_req[d] = 1'b0;
            end
            if (abort_k == k) mem_req[d] = 1'b0;
        end
        mem_req[d] = 1'b0;
    endtask

    task automatic txn_check(input int d, input bit wr, input logic [31:0] addr,
                             input logic [31:0] data, input int abort_k,
                             input bit exp_err, input logic [31:0] exp_rd,
                             input string name);
        bit got, err;
        int lat;
        logic [31:0] rd;
        run_txn(d, wr, addr, data, abort_k, got, lat, rd, err);
        if (abort_k > 0) begin
            chk({name, "_no_ready"}, {31'd0, got}, 32'd0);
        end else begin
            chk({name, "_ready"}, {31'd0, got}, 32'd1);
            if (got) begin
                chk({name, "_lat"}, lat, lat_of(d));
                chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
                if (!wr) begin
                    chk({name, "_rdata"}, rd, exp_rd);
                    last_rd[d] = exp_rd;
                end
            end
        end
        chk({name, "_hold"}, rd_o[d], last_rd[d]);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        rst_n = 1'b0;
        repeat (2) @(negedge CLK);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) last_rd[d] = '0;
    endtask

    // mem_req held high continuously with writes; pulses every LATENCY+1.
    task automatic b2b(input int d, input int npulse);
        int cnt, t_last, budget, lat;
        bit prev;
        lat = lat_of(d);
        cnt = 0; t_last = 0; prev = 1'b0;
        budget = npulse * (lat + 1) + lat + 4;
        @(negedge CLK);
        wr_i[d] = 1'b1; addr_i[d] = 32'h0; data_i[d] = 32'hC0FFEE00; mem_req[d] = 1'b1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge CLK); #1;
            if (prev) begin
                chk($sformatf("b2b_L%0d_width", lat), {31'd0, rdy_o[d]}, 32'd0);
                if (cnt == npulse) break;
            end else if (rdy_o[d]) begin
                cnt++;
                if (cnt == 1) chk($sformatf("b2b_L%0d_first", lat), k, lat);
                else          chk($sformatf("b2b_L%0d_period", lat), k - t_last, lat + 1);
                t_last = k;
            end
            prev = rdy_o[d];
        end
        mem_req[d] = 1'b0;
        chk($sformatf("b2b_L%0d_count", lat), cnt, npulse);
        repeat (3) @(negedge CLK);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        int          abort_k;
        bit          exp_err;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    vec_t tbl[$];

    initial begin
        bit          wr, exp_err;
        int          ab, kind, idx;
        logic [31:0] addr, w, exp_rd;

        for (int d = 0; d < 3; d++) begin
            mem_req[d] = 1'b0; wr_i[d] = 1'b0; addr_i[d] = '0; data_i[d] = '0;
            last_rd[d] = '0;
        end

        tbl.push_back('{1'b0, 32'h0000000C, 32'h0,        0, 1'b0, 32'hDEADBEEF, "rd_after_reset"});
        tbl.push_back('{1'b1, 32'h00000040, 32'h12345678, 0, 1'b0, 32'h0,        "wr_40"});
        tbl.push_back('{1'b0, 32'h00000040, 32'h0,        0, 1'b0, 32'h12345678, "rd_40"});
        tbl.push_back('{1'b1, 32'h00000080, 32'h0BADF00D, 0, 1'b0, 32'h0,        "wr_80_prior"});
        tbl.push_back('{1'b1, 32'h00000080, 32'hAAAA5555, 2, 1'b0, 32'h0,        "wr_80_abort"});
        tbl.push_back('{1'b0, 32'h00000080, 32'h0,        0, 1'b0, 32'h0BADF00D, "rd_80"});
        tbl.push_back('{1'b1, 32'h00000000, 32'h01020304, 0, 1'b0, 32'h0,        "wr_0"});
        tbl.push_back('{1'b0, 32'h00001000, 32'h0,        0, 1'b1, 32'h0,        "rd_oor"});
        tbl.push_back('{1'b1, 32'h00000042, 32'hFFFFFFFF, 0, 1'b1, 32'h0,        "wr_misal"});
        tbl.push_back('{1'b0, 32'h00000040, 32'h0,        0, 1'b0, 32'h12345678, "rd_40_unchg"});
        tbl.push_back('{1'b1, 32'h00001000, 32'h00000055, 0, 1'b1, 32'h0,        "wr_oor"});
        tbl.push_back('{1'b1, 32'h00000010, 32'h11111111, 0, 1'b0, 32'h0,        "wr_10"});
        tbl.push_back('{1'b0, 32'h00000000, 32'h0,        0, 1'b0, 32'h01020304, "rd_0_unchg"});

        // Preload word 3, then reset: array survives reset, outputs do not.
        repeat (3) @(negedge CLK);
        rst_n = 1'b1;
        txn_check(0, 1'b1, 32'h0000000C, 32'hDEADBEEF, 0, 1'b0, 32'h0, "preload");
        do_reset();
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset_rdata%0d", d), rd_o[d], 32'h0);
            chk($sformatf("reset_ready%0d", d), {31'd0, rdy_o[d]}, 32'd0);
            chk($sformatf("reset_err%0d", d), {31'd0, err_o[d]}, 32'd0);
        end

        foreach (tbl[i]) begin
            txn_check(0, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].abort_k,
                      tbl[i].exp_err, tbl[i].exp_rd, tbl[i].name);
        end

        // Reset during WAIT of a write to 0x10: outputs clear at once and
        // the pending write never lands.
        @(negedge CLK);
        wr_i[0] = 1'b1; addr_i[0] = 32'h10; data_i[0] = 32'h22222222; mem_req[0] = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        rst_n = 1'b0; mem_req[0] = 1'b0;
        #1;
        chk("rstwait_rdata", rd_o[0], 32'h0);
        chk("rstwait_ready", {31'd0, rdy_o[0]}, 32'd0);
        chk("rstwait_err", {31'd0, err_o[0]}, 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        for (int d = 0; d < 3; d++) last_rd[d] = '0;
        txn_check(0, 1'b0, 32'h10, 32'h0, 0, 1'b0, 32'h11111111, "rstwait_rd_10");

        // Randomized traffic against the word-array model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                w = $urandom;
                txn_check(d, 1'b1, 32'(i * 4), w, 0, 1'b0, 32'h0, "rnd_init");
                model[d][i] = w;
            end
            for (int n = 0; n < 30; n++) begin
                idx  = int'($urandom_range(0, 15));
                kind = int'($urandom_range(0, 7));
                if (kind <= 4)      addr = 32'(idx * 4);
                else if (kind == 5) addr = 32'(idx * 4) + $urandom_range(1, 3);
                else if (kind == 6) addr = 32'h1000 + 32'(idx * 4);
                else                addr = 32'h80000000 | 32'(idx * 4);
                wr = 1'($urandom_range(0, 1));
                w  = $urandom;
                ab = 0;
                if (lat_of(d) > 1 && $urandom_range(0, 5) == 0)
                    ab = int'($urandom_range(1, lat_of(d) - 1));
                exp_err = (addr % 4 != 0) || (addr >= 32'd4096);
                exp_rd  = exp_err ? 32'h0 : model[d][addr / 4];
                txn_check(d, wr, addr, w, ab, exp_err, exp_rd, "rnd");
                if (ab == 0 && wr && !exp_err) model[d][addr / 4] = w;
            end
        end

        b2b(1, 6);
        b2b(2, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_data_memory_responder
`default_nettype wire
